arb_rr2x1_8bits: RTL
====================

// Module: arb_rr2x1_8bits
// PURPOSE
//   Round-robin scheduler for the 2:1 8-bit lane mux. Two requesters (lane 00 and lane 11)
//   present valid/data. The block grants one per cycle, pops the granted source and drives a
//   registered 8-bit output stream with downstream backpressure. Bursts are bounded so neither
//   lane can starve the other. It sits between the per-lane buffers and the serializer stage,
//   all in the clk_4f domain.
// PARAMETERS
//   BURST_MAX  4   max consecutive beats granted to one lane while the other lane is requesting (>=1)
//   CNT_W      16  width of the per-lane beat counters
// PORTS
//   clk_4f       in   1      single clock, all logic on rising edge
//   reset        in   1      synchronous, active-high
//   data_00      in   8      lane 00 data
//   valid_00     in   1      lane 00 has a beat available
//   data_11      in   8      lane 11 data
//   valid_11     in   1      lane 11 has a beat available
//   ready_out    in   1      downstream accepts data_out this cycle
//   pop_00       out  1      lane 00 beat consumed this cycle (combinational)
//   pop_11       out  1      lane 11 beat consumed this cycle (combinational)
//   data_out     out  8      registered output data
//   valid_out    out  1      registered output valid
//   sel_out      out  1      source of the current data_out: 0 = lane 00, 1 = lane 11
//   beat_cnt_00  out  CNT_W  beats popped from lane 00; wraps at 2^CNT_W
//   beat_cnt_11  out  CNT_W  beats popped from lane 11; wraps at 2^CNT_W
// BEHAVIOUR
//   Reset values, applied on the clock edge with reset=1:
//     data_out=0, valid_out=0, sel_out=0, beat counters=0, state=IDLE, burst_cnt=0,
//     last_served=1 (so lane 00 wins the first tie).
//   While reset=1, pop_00 and pop_11 are forced to 0. Reset asserted mid-burst aborts the burst.
//   load = ready_out | ~valid_out. Everything updates only when load=1. When load=0, all
//     registers hold and pop_xx=0.
//   Latency: a beat popped in cycle N appears on data_out/valid_out in cycle N+1.
//   FSM states: IDLE, SERV_00, SERV_11. x = the lane being served, y = the other lane.
//     IDLE:
//       neither lane valid -> stay in IDLE.
//       one lane valid     -> grant it.
//       both lanes valid   -> grant the lane != last_served.
//     SERV_x, keep x:
//       valid_x & (burst_cnt<BURST_MAX | ~valid_y) -> grant x again.
//     SERV_x, switch to y:
//       valid_y & (~valid_x | burst_cnt==BURST_MAX) -> grant y.
//     SERV_x, go idle:
//       ~valid_x & ~valid_y -> IDLE.
//   Grant of lane g (with load=1):
//     pop_g=1; data_out<=data_g; valid_out<=1; sel_out<=g; last_served<=g;
//     state<=SERV_g; beat_cnt_g increments.
//     burst_cnt<=1 when entering g from IDLE or from the other lane.
//     When continuing g: burst_cnt<=min(burst_cnt+1, BURST_MAX) (saturates).
//   No grant (with load=1): valid_out<=0, data_out<=0, sel_out holds, burst_cnt<=0.
//   Never more than one pop per cycle. pop_g requires valid_g=1.
// TESTING
//   T1 Reset: hold reset 2 cycles with both lanes valid -> pops=0, valid_out=0, data_out=0,
//      counters=0.
//   T2 Single lane: valid_00=1, data 0x01..0x06, ready_out=1 -> pop_00 for 6 cycles;
//      data_out=0x01..0x06 one cycle later; sel_out=0; beat_cnt_00=6; valid_out drops after.
//   T3 Fairness: BURST_MAX=2, both lanes valid continuously, ready_out=1 ->
//      sel_out sequence 0,0,1,1,0,0,1,1.
//   T4 Backpressure: ready_out=0 for 3 cycles while valid_out=1 (data_out=0xA5) ->
//      data_out stays 0xA5, no pops, counters frozen; resumes on the next beat when ready_out=1.
//   T5 Idle round-robin: single-cycle requests alternating 00 (0x10) and 11 (0x20) with idle
//      gaps -> IDLE between beats. A later simultaneous request picks the lane not last served.
//   T6 Mid-burst reset: reset for 1 cycle during the 2nd beat of a lane 11 burst ->
//      next cycle valid_out=0 and counters=0. After release with both lanes valid, the first
//      grant is lane 00.

Source files
------------

// File: rtl/arb_rr2x1_8bits.sv
// ============================================================================
// Module      : arb_rr2x1_8bits
// Description : Round-robin 2:1 scheduler for two 8-bit lanes. Bursts are
//               bounded, the output is registered and honours downstream
//               backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr2x1_8bits #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [7:0]       data_00,
    input  logic             valid_00,
    input  logic [7:0]       data_11,
    input  logic             valid_11,
    input  logic             ready_out,
    output logic             pop_00,
    output logic             pop_11,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             sel_out,
    output logic [CNT_W-1:0] beat_cnt_00,
    output logic [CNT_W-1:0] beat_cnt_11
);

    localparam int         c_BW        = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [c_BW-1:0] c_BURST_MAX = c_BW'(BURST_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERV_00 = 2'd1,
        S_SERV_11 = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_BW-1:0]   r_burst;
    logic              r_last_served;
    logic [7:0]        r_data_out;
    logic              r_valid_out;
    logic              r_sel_out;
    logic [CNT_W-1:0]  r_cnt_00;
    logic [CNT_W-1:0]  r_cnt_11;

    logic              w_load;
    logic              w_in_serv;
    logic              w_cur;
    logic              w_vx;
    logic              w_vy;
    logic              w_grant;
    logic              w_lane;
    logic              w_cont;

    assign w_load    = ready_out | ~r_valid_out;
    assign w_in_serv = (r_state == S_SERV_00) || (r_state == S_SERV_11);
    assign w_cur     = (r_state == S_SERV_11);
    assign w_vx      = w_cur ? valid_11 : valid_00;
    assign w_vy      = w_cur ? valid_00 : valid_11;

    // Grant decision; the burst counter saturates at BURST_MAX, so failing the
    // "< BURST_MAX" test while serving means the burst limit has been reached.
    always_comb begin
        w_grant = 1'b0;
        w_lane  = 1'b0;
        if (w_in_serv) begin
            if (w_vx && ((r_burst < c_BURST_MAX) || !w_vy)) begin
                w_grant = 1'b1;
                w_lane  = w_cur;
            end else if (w_vy) begin
                w_grant = 1'b1;
                w_lane  = ~w_cur;
            end
        end else begin
            if (valid_00 && valid_11) begin
                w_grant = 1'b1;
                w_lane  = ~r_last_served;
            end else if (valid_00) begin
                w_grant = 1'b1;
                w_lane  = 1'b0;
            end else if (valid_11) begin
                w_grant = 1'b1;
                w_lane  = 1'b1;
            end
        end
    end

    assign w_cont = w_grant && w_in_serv && (w_lane == w_cur);

    assign pop_00 = ~reset & w_load & w_grant & ~w_lane;
    assign pop_11 = ~reset & w_load & w_grant &  w_lane;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_burst       <= '0;
            r_last_served <= 1'b1;
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_sel_out     <= 1'b0;
            r_cnt_00      <= '0;
            r_cnt_11      <= '0;
        end else if (w_load) begin
            if (w_grant) begin
                r_data_out    <= w_lane ? data_11 : data_00;
                r_valid_out   <= 1'b1;
                r_sel_out     <= w_lane;
                r_last_served <= w_lane;
                r_state       <= w_lane ? S_SERV_11 : S_SERV_00;
                if (w_cont) begin
                    if (r_burst != c_BURST_MAX) begin
                        r_burst <= r_burst + c_BW'(1);
                    end
                end else begin
                    r_burst <= c_BW'(1);
                end
                if (w_lane) begin
                    r_cnt_11 <= r_cnt_11 + CNT_W'(1);
                end else begin
                    r_cnt_00 <= r_cnt_00 + CNT_W'(1);
                end
            end else begin
                r_data_out  <= '0;
                r_valid_out <= 1'b0;
                r_burst     <= '0;
                r_state     <= S_IDLE;
            end
        end
    end

    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign sel_out     = r_sel_out;
    assign beat_cnt_00 = r_cnt_00;
    assign beat_cnt_11 = r_cnt_11;

endmodule

`default_nettype wire
